// File: rtl/frame_buffer_pingpong.sv
// frame_buffer_pingpong
//   Double-buffered frame store. The pixel writer fills the back bank while
//   the display reader scans the front bank. The banks swap only on a display
//   frame start that follows a completed write frame, so the display never
//   shows a half-written frame.
//
//   Ports:
//     clk, reset       system clock, asynchronous active-high reset
//     rd_en/rd_addr    read request; result one cycle later on rd_data/rd_valid
//     rd_frame_start   display vsync pulse; the only point where a swap happens
//     wr_en/wr_addr/
//     wr_data          write strobe into the back bank (ignored when !wr_ready)
//     wr_frame_done    writer has finished filling the back bank
//     wr_ready         back bank is accepting writes
//     front_bank       bank currently being displayed
//     repeat_cnt       saturating count of frames that re-showed the old bank
//
//   state   | meaning
//   FILL    | writer owns the back bank, writes accepted
//   PENDING | back bank complete, waiting for frame start to swap
module frame_buffer_pingpong #(
  parameter int unsigned       DATA_W = 12,
  parameter int unsigned       ADDR_W = 19,
  parameter int unsigned       DEPTH  = 420000,
  parameter int unsigned       WIN_LO = 28000,
  parameter int unsigned       WIN_HI = 411999,
  parameter logic [DATA_W-1:0] BLANK  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_frame_start,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  output logic              wr_ready,
  output logic              front_bank,
  output logic [7:0]        repeat_cnt
);

  typedef enum logic {FILL, PENDING} state_t;

  state_t            state_q, state_d;
  logic              front_q, front_d;
  logic [7:0]        repeat_q, repeat_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  // Compare addresses at 32 bits so the int parameters need no truncation.
  logic [31:0] rd_addr_ext, wr_addr_ext;
  logic        rd_in_win, wr_ok;

  assign rd_addr_ext = 32'(rd_addr);
  assign wr_addr_ext = 32'(wr_addr);
  assign rd_in_win   = (rd_addr_ext >= WIN_LO) && (rd_addr_ext <= WIN_HI) &&
                       (rd_addr_ext < DEPTH);
  assign wr_ok       = wr_en && (state_q == FILL) && (wr_addr_ext < DEPTH);

  // Write port always targets the bank that is not being displayed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (front_q) bank0[wr_addr] <= wr_data;
      else         bank1[wr_addr] <= wr_data;
    end
  end

  // Read uses front_q of the request cycle, so a read in the swap cycle
  // still sees the old bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= BLANK;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        if (!rd_in_win)   rd_data_q <= BLANK;
        else if (front_q) rd_data_q <= bank1[rd_addr];
        else              rd_data_q <= bank0[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      front_q  <= 1'b0;
      repeat_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      front_q  <= front_d;
      repeat_q <= repeat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    front_d  = front_q;
    repeat_d = repeat_q;
    unique case (state_q)
      FILL: begin
        if (wr_frame_done) state_d = PENDING;
        // A frame start in FILL re-shows the old bank, even when the writer
        // finishes in the same cycle: that swap waits for the next frame.
        if (rd_frame_start && (repeat_q != 8'hFF)) repeat_d = repeat_q + 8'd1;
      end
      PENDING: begin
        if (rd_frame_start) begin
          front_d = ~front_q;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign wr_ready   = (state_q == FILL);
  assign front_bank = front_q;
  assign repeat_cnt = repeat_q;

endmodule

// File: doc/frame_buffer_pingpong.md
Name: frame_buffer_pingpong

Overview:
- Double-buffered (ping-pong) frame store for the video path.
- The pixel writer (camera/processing side) fills the back bank while the display reader scans the front bank.
- Banks swap only on a display frame boundary, after the writer declares its frame complete. This prevents tearing.
- Generalises the single-bank frame RAM: data width, depth and visible window are parameters; adds read-valid, blanking outside the window and swap handshake.

Parameters:
DATA_W, 12, pixel width in bits (RGB444 default)
ADDR_W, 19, address width of both ports
DEPTH, 420000, pixels per bank, including non-displayed pixels
WIN_LO, 28000, first displayed address, inclusive
WIN_HI, 411999, last displayed address, inclusive
BLANK, 0, value of rd_data for reads outside the window or at/after DEPTH

Ports:
clk  input  1  single system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
rd_en  input  1  read request this cycle
rd_addr  input  ADDR_W  read pixel address
rd_frame_start  input  1  one-cycle pulse at display frame start (vsync)
rd_data  output  DATA_W  registered read data
rd_valid  output  1  rd_data valid this cycle
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write pixel address
wr_data  input  DATA_W  write pixel data
wr_frame_done  input  1  one-cycle pulse: back bank holds a complete frame
wr_ready  output  1  back bank accepts writes
front_bank  output  1  index of bank currently displayed
repeat_cnt  output  8  saturating count of display frames that re-showed the old front bank

Behaviour:
- Storage: two banks of DEPTH x DATA_W, inferred block RAM.
- Memory contents are not reset.
- Reset (async assert, sync release) values:
  - rd_data = BLANK, rd_valid = 0
  - front_bank = 0, state = FILL
  - wr_ready = 1, repeat_cnt = 0
- Read path, latency exactly 1 cycle:
  - The cycle after rd_en = 1, rd_valid = 1.
  - If WIN_LO <= rd_addr <= WIN_HI and rd_addr < DEPTH, rd_data = bank[front_bank][rd_addr]; otherwise rd_data = BLANK.
  - When rd_en = 0, rd_valid = 0 and rd_data holds its last value.
  - The bank used is the front_bank value in the request cycle. A read issued in the swap cycle uses the old bank.
- Write path:
  - On wr_en and wr_ready with wr_addr < DEPTH, write wr_data to bank[~front_bank][wr_addr].
  - Writes with wr_addr >= DEPTH, or while wr_ready = 0, are dropped silently.
  - Read and write never target the same bank, so there is no read/write collision.
- State machine:
  - FILL (wr_ready = 1):
    - wr_frame_done -> PENDING.
    - rd_frame_start without wr_frame_done -> repeat_cnt + 1, saturating at 255; stay in FILL.
    - Both in the same cycle -> PENDING, and repeat_cnt increments. The swap waits for the next rd_frame_start.
  - PENDING (wr_ready = 0):
    - rd_frame_start -> front_bank toggles on that edge -> FILL; wr_ready = 1 from the next cycle.
    - Extra wr_frame_done pulses are ignored.
- A write accepted in the same cycle as wr_frame_done is committed.
- Reset mid-frame: an in-flight read result is discarded (rd_valid = 0); pending swap is cancelled; front_bank returns to 0.

Test Plan:
- Reset, then write 0xABC at address 30000 in back bank 1, pulse wr_frame_done, pulse rd_frame_start; read 30000 -> one cycle later rd_valid = 1, rd_data = 0xABC, front_bank = 1.
- Read addresses 27999, 412000 and 419999, all holding written non-zero data -> rd_data = 0x000, rd_valid = 1 each. Read 28000 and 411999 -> stored values.
- Three rd_frame_start pulses with no wr_frame_done -> repeat_cnt = 3, front_bank unchanged. Drive 300 such pulses -> repeat_cnt = 255.
- wr_frame_done, then write 0x123 to address 30000 while PENDING -> write dropped; after the swap, address 30000 reads the pre-PENDING value.
- wr_frame_done and rd_frame_start in the same cycle -> no swap that frame, repeat_cnt + 1; the swap happens at the next rd_frame_start.
- Assert reset while PENDING with rd_en high -> rd_valid = 0 immediately, front_bank = 0, wr_ready = 1, repeat_cnt = 0.
